// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and screen constants for the sprite position path
// Contents:
//   COORD_W            width of committed sprite coordinates
//   CALC_W             signed working width for next-position arithmetic
//   H_ACTIVE/V_ACTIVE  1080p visible area, shared with the VGA controller
//   posState_t         controller FSM states
//   axisDelta()        signed per-axis step from an opposing button pair
package sprite_pkg;

    localparam int COORD_W  = 11;
    localparam int CALC_W   = 12;
    localparam int H_ACTIVE = 1920;
    localparam int V_ACTIVE = 1080;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } posState_t;

    // Opposing buttons held together cancel to zero movement.
    function automatic logic signed [CALC_W-1:0] axisDelta(
        input logic                     posBtn,
        input logic                     negBtn,
        input logic signed [CALC_W-1:0] step
    );
        if (posBtn && !negBtn) begin
            return step;
        end else if (negBtn && !posBtn) begin
            return -step;
        end else begin
            return '0;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus stable-count debouncer for one button
// Ports:
//   clk       pixel clock
//   reset     asynchronous active-low reset; debounced level clears to 0
//   btnRaw    raw asynchronous button, active-high
//   btnLevel  debounced level; follows the synchronized input only after
//             DB_CYCLES consecutive samples at the new value
module btn_debounce #(
    parameter int DB_CYCLES = 1485000
) (
    input  logic clk,
    input  logic reset,
    input  logic btnRaw,
    output logic btnLevel
);

    localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       syncQ;
    logic [CNT_W-1:0] stableCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncQ     <= '0;
            stableCnt <= '0;
            btnLevel  <= 1'b0;
        end else begin
            syncQ <= {syncQ[0], btnRaw};
            // The count only runs while the synchronized input disagrees with
            // the accepted level, so any agreeing sample restarts it.
            if (syncQ[1] == btnLevel) begin
                stableCnt <= '0;
            end else if (stableCnt == CNT_LAST) begin
                btnLevel  <= syncQ[1];
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_pos_ctrl.sv
// rtl/sprite_pos_ctrl.sv - frame-synchronous sprite position controller driven by push-buttons
// Ports:
//   clk          148.5 MHz pixel clock
//   reset        asynchronous active-low reset
//   btnU/D/L/R   raw asynchronous buttons, active-high
//   frame_start  one-cycle pulse at the first line of vertical blanking
//   spr_x/spr_y  committed sprite top-left coordinate
//   upd_valid    one-cycle pulse when spr_x/spr_y are committed
// Build option: SPRITE_WRAP_EN selects wrap-around at the screen edges
// instead of clamping.
module sprite_pos_ctrl
    import sprite_pkg::*;
#(
    parameter int H_ACTIVE  = sprite_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = sprite_pkg::V_ACTIVE,
    parameter int SPR_W     = 64,
    parameter int SPR_H     = 64,
    parameter int STEP      = 4,
    parameter int DB_CYCLES = 1485000,
    parameter int X_INIT    = 928,
    parameter int Y_INIT    = 508
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btnU,
    input  logic               btnD,
    input  logic               btnL,
    input  logic               btnR,
    input  logic               frame_start,
    output logic [COORD_W-1:0] spr_x,
    output logic [COORD_W-1:0] spr_y,
    output logic               upd_valid
);

    localparam logic signed [CALC_W-1:0] X_MAX  = CALC_W'(H_ACTIVE - SPR_W);
    localparam logic signed [CALC_W-1:0] Y_MAX  = CALC_W'(V_ACTIVE - SPR_H);
    localparam logic signed [CALC_W-1:0] STEP_S = CALC_W'(STEP);

    function automatic logic signed [CALC_W-1:0] fitAxis(
        input logic signed [CALC_W-1:0] value,
        input logic signed [CALC_W-1:0] maxVal
    );
`ifdef SPRITE_WRAP_EN
        // STEP never exceeds the sprite size, so one correction is enough.
        if (value < 12'sd0) begin
            return value + maxVal + 12'sd1;
        end else if (value > maxVal) begin
            return value - maxVal - 12'sd1;
        end else begin
            return value;
        end
`else
        if (value < 12'sd0) begin
            return 12'sd0;
        end else if (value > maxVal) begin
            return maxVal;
        end else begin
            return value;
        end
`endif
    endfunction

    logic dbU, dbD, dbL, dbR;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) uDebU (.clk(clk), .reset(reset), .btnRaw(btnU), .btnLevel(dbU));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) uDebD (.clk(clk), .reset(reset), .btnRaw(btnD), .btnLevel(dbD));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) uDebL (.clk(clk), .reset(reset), .btnRaw(btnL), .btnLevel(dbL));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) uDebR (.clk(clk), .reset(reset), .btnRaw(btnR), .btnLevel(dbR));

    posState_t state, nextState;
    logic      calcEn;
    logic      commitEn;

    logic signed [CALC_W-1:0] rawX, rawY;
    logic signed [CALC_W-1:0] nx, ny;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // frame_start is only looked at in IDLE; pulses during CALC/COMMIT are dropped.
    always_comb begin
        nextState = state;
        calcEn    = 1'b0;
        commitEn  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    nextState = CALC;
                end
            end
            CALC: begin
                calcEn    = 1'b1;
                nextState = COMMIT;
            end
            COMMIT: begin
                commitEn  = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        rawX = $signed({1'b0, spr_x}) + axisDelta(dbR, dbL, STEP_S);
        rawY = $signed({1'b0, spr_y}) + axisDelta(dbD, dbU, STEP_S);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nx <= CALC_W'(X_INIT);
            ny <= CALC_W'(Y_INIT);
        end else if (calcEn) begin
            nx <= fitAxis(rawX, X_MAX);
            ny <= fitAxis(rawY, Y_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spr_x     <= COORD_W'(X_INIT);
            spr_y     <= COORD_W'(Y_INIT);
            upd_valid <= 1'b0;
        end else begin
            upd_valid <= commitEn;
            if (commitEn) begin
                spr_x <= COORD_W'(nx);
                spr_y <= COORD_W'(ny);
            end
        end
    end

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// tb/tb_sprite_pos_ctrl.sv - directed self-checking bench for sprite_pos_ctrl
module tb_sprite_pos_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btnU = 1'b0;
    logic        btnD = 1'b0;
    logic        btnL = 1'b0;
    logic        btnR = 1'b0;
    logic        frame_start = 1'b0;
    logic [10:0] spr_x;
    logic [10:0] spr_y;
    logic        upd_valid;

    int cmpCnt = 0;
    int errCnt = 0;
    int expX = 928;
    int expY = 508;

    always #5 clk = ~clk;

    sprite_pos_ctrl #(.DB_CYCLES(16)) dut (
        .clk(clk),
        .reset(reset),
        .btnU(btnU),
        .btnD(btnD),
        .btnL(btnL),
        .btnR(btnR),
        .frame_start(frame_start),
        .spr_x(spr_x),
        .spr_y(spr_y),
        .upd_valid(upd_valid)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        cmpCnt++;
        assert (obs === expv) else begin
            errCnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One frame update: frame_start sampled at edge k, commit visible at k+2.
    // holdTwo keeps frame_start high across edge k+1 to show it is not queued.
    task automatic doFrame(input string tag, input int newX, input int newY, input bit holdTwo);
        frame_start = 1'b1;
        tick();
        if (!holdTwo) frame_start = 1'b0;
        check({tag, "_k_upd"}, upd_valid, 0);
        tick();
        frame_start = 1'b0;
        check({tag, "_k1_upd"}, upd_valid, 0);
        check({tag, "_k1_x"}, spr_x, expX);
        check({tag, "_k1_y"}, spr_y, expY);
        tick();
        check({tag, "_k2_upd"}, upd_valid, 1);
        check({tag, "_k2_x"}, spr_x, newX);
        check({tag, "_k2_y"}, spr_y, newY);
        tick();
        check({tag, "_k3_upd"}, upd_valid, 0);
        if (holdTwo) begin
            tick(2);
            check({tag, "_k5_upd"}, upd_valid, 0);
            check({tag, "_k5_x"}, spr_x, newX);
        end
        expX = newX;
        expY = newY;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_x", spr_x, 928);
        check("rst_y", spr_y, 508);
        check("rst_upd", upd_valid, 0);
        reset = 1'b1;
        tick();

        // Frame with no buttons: pulse but no movement
        doFrame("idle", 928, 508, 1'b0);

        // Right move; second frame_start cycle lands in CALC and is ignored
        btnR = 1'b1;
        tick(24);
        doFrame("right", 932, 508, 1'b1);
        btnR = 1'b0;
        tick(24);

        // Glitch shorter than the debounce window
        btnU = 1'b1;
        tick(10);
        btnU = 1'b0;
        tick(24);
        doFrame("glitch", 932, 508, 1'b0);

        // Opposing buttons cancel
        btnL = 1'b1;
        btnR = 1'b1;
        tick(24);
        doFrame("cancel", 932, 508, 1'b0);
        btnL = 1'b0;
        btnR = 1'b0;
        tick(24);

        // Reset during CALC discards the pending update
        btnD = 1'b1;
        tick(24);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_x", spr_x, 928);
        check("midrst_y", spr_y, 508);
        check("midrst_upd", upd_valid, 0);
        tick(3);
        check("midrst_upd_late", upd_valid, 0);
        check("midrst_y_late", spr_y, 508);
        reset = 1'b1;
        expX = 928;
        expY = 508;
        tick(24);
        doFrame("after_rst", 928, 512, 1'b0);
        btnD = 1'b0;
        tick(24);

        // Walk left to the left edge, then one more step
        btnL = 1'b1;
        tick(24);
        for (int i = 1; i <= 232; i++) begin
            doFrame("left_run", 928 - 4 * i, 512, 1'b0);
        end
`ifdef SPRITE_WRAP_EN
        doFrame("left_edge", 1853, 512, 1'b0);
`else
        doFrame("left_edge", 0, 512, 1'b0);
`endif
        btnL = 1'b0;

        // Back to reset position, walk right to X_MAX-4, then three frames at the edge
        reset = 1'b0;
        tick();
        check("rst2_x", spr_x, 928);
        check("rst2_y", spr_y, 508);
        reset = 1'b1;
        expX = 928;
        expY = 508;
        btnR = 1'b1;
        tick(24);
        for (int i = 1; i <= 231; i++) begin
            doFrame("right_run", 928 + 4 * i, 508, 1'b0);
        end
        check("right_1852", spr_x, 1852);
`ifdef SPRITE_WRAP_EN
        doFrame("right_edge1", 1856, 508, 1'b0);
        doFrame("right_edge2", 3, 508, 1'b0);
        doFrame("right_edge3", 7, 508, 1'b0);
`else
        doFrame("right_edge1", 1856, 508, 1'b0);
        doFrame("right_edge2", 1856, 508, 1'b0);
        doFrame("right_edge3", 1856, 508, 1'b0);
`endif
        btnR = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/sprite_pos_ctrl.md
# sprite_pos_ctrl

Frame-synchronous position controller for the movable sprite drawn by the 1080p VGA pipeline. It synchronizes and debounces the four board push-buttons, then updates the sprite's top-left coordinate once per frame at the start of vertical blanking. Edges are clamped, or wrapped when the wrap feature is compiled in. It sits between the button inputs and the VGA controller in the 148.5 MHz pixel-clock domain, so the position never changes while a frame is being drawn.

## Interface
- H_ACTIVE, 1920, visible pixels per line
- V_ACTIVE, 1080, visible lines per frame
- SPR_W, 64, sprite width in pixels
- SPR_H, 64, sprite height in lines
- STEP, 4, pixels moved per frame per held direction (1..SPR_W)
- DB_CYCLES, 1485000, consecutive stable samples needed to accept a button change (10 ms at 148.5 MHz)
- X_INIT, 928, reset x coordinate
- Y_INIT, 508, reset y coordinate

Ports:
- clk  in  1  pixel clock (148.5 MHz); all logic on the rising edge
- reset  in  1  asynchronous, active-low; clears all state
- btnU / btnD / btnL / btnR  in  1 each  raw, asynchronous buttons; active-high
- frame_start  in  1  one-cycle pulse from the VGA controller on the first line of vertical blanking
- spr_x  out  11  committed sprite x; reset value X_INIT
- spr_y  out  11  committed sprite y; reset value Y_INIT
- upd_valid  out  1  one-cycle pulse when spr_x/spr_y are committed; reset value 0

## Operation
- **Button conditioning**
  - Each button passes through a 2-FF synchronizer, then a debouncer.
  - Debounced level changes only after DB_CYCLES consecutive cycles at the new synchronized value.
  - Any mismatching sample restarts the count.
  - Debounced levels reset to 0.
- **FSM states: IDLE, CALC, COMMIT**
  - IDLE: waits for frame_start=1, then goes to CALC.
  - CALC: registers nx/ny from the debounced levels, then goes to COMMIT.
  - COMMIT: loads spr_x/spr_y from nx/ny, pulses upd_valid, then returns to IDLE.
  - frame_start pulses seen in CALC or COMMIT are ignored (not queued).
- **Arithmetic**
  - Computed in 12-bit signed.
  - dx = (R − L)·STEP and dy = (D − U)·STEP. Opposing buttons held together cancel to 0.
  - X_MAX = H_ACTIVE − SPR_W; Y_MAX = V_ACTIVE − SPR_H.
  - Default behaviour clamps: results < 0 become 0; results > MAX become MAX.
- **Diagonals:** x and y update independently in the same frame.
- **Reset mid-operation:** asserting reset in any state returns to IDLE with outputs at reset values. A pending update is discarded.

## Timing
- Let edge k be the rising edge that samples frame_start=1 in IDLE.
  - CALC holds after edge k.
  - nx/ny are registered at edge k+1.
  - spr_x, spr_y and upd_valid change at edge k+2; upd_valid drops at edge k+3.
- Button-to-effect latency:
  - 2 synchronizer cycles + DB_CYCLES to reach the debounced level.
  - After that, the effect appears at the next frame_start.
- The button level used for an update is the level sampled at edge k+1.
- spr_x/spr_y are stable at all other times. The controller is ready again from edge k+3.

## Configuration
- SPRITE_WRAP_EN defined:
  - Replaces clamping with wrap-around.
  - x < 0 becomes x + X_MAX + 1; x > X_MAX becomes x − X_MAX − 1. y behaves the same using Y_MAX.
- SPRITE_WRAP_EN undefined: clamp behaviour as in Operation.
- Interface and timing are identical in both builds.

## Structure
- Shared package sprite_pkg holds:
  - the FSM state enum
  - the coordinate width constant (11)
  - the 1080p screen constants H_ACTIVE/V_ACTIVE used by both this block and the VGA controller
- One sub-module, btn_debounce (synchronizer + stable counter, parameter DB_CYCLES), instantiated four times.

## Test plan
Bench uses DB_CYCLES=16 and default other parameters.
- **Reset:** assert reset low → spr_x=928, spr_y=508, upd_valid=0. Pulse frame_start with no buttons → upd_valid pulses 2 edges later; position unchanged.
- **Right move:** btnR held 20 cycles, then frame_start → spr_x=932 at edge k+2; spr_y=508; exactly one upd_valid pulse.
- **Glitch rejection and cancel:**
  - btnU high for 10 cycles, then low, then frame_start → no change.
  - btnL and btnR both held, then frame_start → no change.
- **Right-edge clamp:** reach spr_x=1852 (X_MAX−4), hold btnR, pulse frame_start 3 times → spr_x=1856, 1856, 1856.
- **Reset mid-update:** pulse frame_start with btnD held, then drop reset during CALC → spr_y=508 and no upd_valid pulse. Next frame_start after release → spr_y=512.
- **Wrap build (SPRITE_WRAP_EN):** spr_x=0, hold btnL, pulse frame_start → spr_x=1853.
